mem_wb_skid: RTL
================

MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DW, 32, datapath width of pc, aluresult and memdata.
- RW, 5, register-address width of swdst.
- MW, 2, width of memtoreg.
REQ-002 Ports, one per line (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous, active-low reset.
- flush, in, 1, synchronous kill of all held entries.
- in_valid, in, 1, upstream holds a valid MEM-stage bundle.
- in_ready, out, 1, stage can accept a bundle this cycle.
- pc_in, in, DW, instruction PC.
- aluresult_in, in, DW, ALU result.
- memdata_in, in, DW, load data.
- swdst_in, in, RW, destination register.
- regwrite_in, in, 1, destination write request.
- memtoreg_in, in, MW, writeback source select.
- out_valid, out, 1, head bundle is valid.
- out_ready, in, 1, writeback consumes the head bundle this cycle.
- pc, aluresult, memdata, swdst, regwrite, memtoreg, out, as the matching inputs, head bundle fields.
- wb_data, out, DW, selected writeback value.
- wb_we, out, 1, qualified register-file write enable.
- count, out, 2, occupancy (0..2).

Function
REQ-003 The block SHALL hold two entries: head (drives the outputs) and skid; occupancy is in {EMPTY=0, ONE=1, FULL=2}, and count SHALL equal occupancy.
REQ-004 Signal definitions:
- in_ready SHALL be 1 exactly when occupancy != FULL, decoded from state only (no combinational path from out_ready or in_valid).
- out_valid SHALL be 1 exactly when occupancy != EMPTY.
- accept = in_valid & in_ready.
- release = out_valid & out_ready.
REQ-005 EMPTY: accept SHALL load head and go to ONE; otherwise stay EMPTY.
REQ-006 ONE transitions:
- accept & release SHALL load head with the new bundle and stay ONE.
- accept only SHALL load skid and go to FULL.
- release only SHALL go to EMPTY.
- neither SHALL hold.
REQ-007 FULL: release SHALL copy skid to head and go to ONE; otherwise hold. No accept is possible because in_ready=0.
REQ-008 Bundles SHALL leave in acceptance order; no bundle SHALL be dropped or duplicated absent flush.
REQ-009 Accept-to-out_valid latency SHALL be 1 cycle when EMPTY; sustained throughput SHALL be 1 bundle/cycle while out_ready=1.
REQ-010 flush=1 SHALL:
- set occupancy to EMPTY at the next edge;
- clear the regwrite bit of both entries;
- take priority over accept and release; a bundle presented with in_valid in the flush cycle SHALL be discarded.
REQ-011 While out_valid=0, payload outputs SHALL hold their last values, but regwrite and wb_we SHALL read 0.
REQ-012 wb_data SHALL select by memtoreg:
- 0 -> aluresult;
- 1 -> memdata;
- 2 or 3 -> pc+4, truncated to DW bits (wraps modulo 2^DW).
REQ-013 wb_we SHALL equal out_valid & out_ready & regwrite & (swdst != 0).
REQ-014 Entry payloads not being loaded SHALL retain value; head and skid load only as stated in REQ-005..REQ-007.

Reset
REQ-015 rst=0 SHALL asynchronously force:
- occupancy EMPTY;
- both entries' fields to 0;
- outputs out_valid=0, in_ready=1, count=0, wb_we=0, wb_data=0, all payload outputs 0.
REQ-016 Reset asserted mid-transfer SHALL discard all entries; the first edge after release with in_valid=1 SHALL accept normally.

Verification
REQ-017 Pass-through: out_ready=1, feed pc=0x100, alu=0x11, memtoreg=0, swdst=3, regwrite=1 -> next cycle out_valid=1, wb_data=0x11, wb_we=1, count=1.
REQ-018 Backpressure: out_ready=0, feed A then B -> count=2, in_ready=0, head=A. Raise out_ready -> A then B on consecutive cycles, then count=0.
REQ-019 Flush with FULL and in_valid=1 -> next cycle count=0, out_valid=0, wb_we=0; the flush-cycle bundle never appears.
REQ-020 Writeback select: memtoreg=1, memdata=0xDEAD -> wb_data=0xDEAD. memtoreg=2, pc=0xFFFFFFFC -> wb_data=0x00000000. swdst=0, regwrite=1 -> wb_we=0.
REQ-021 Async reset: drop rst between edges while count=2 -> immediately count=0, out_valid=0, in_ready=1, all payload outputs 0.
REQ-022 Random stress: random in_valid/out_ready/flush for 10k cycles against a 2-deep FIFO model -> order, count and wb_we match every cycle.

Source files
------------

// File: rtl/mem_wb_skid_if.sv
// MEM/WB skid stage bundle interface.
// Carries the upstream handshake and payload, the downstream handshake and head-bundle fields,
// the writeback value/enable, the occupancy count and the synchronous flush.
// Modports:
//   master - environment side: drives flush, in_valid, *_in payload and out_ready.
//   slave  - the stage itself: drives in_ready, out_valid, head fields, wb_data, wb_we, count.
interface mem_wb_skid_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned MW = 2
) ();
  logic          flush;
  // upstream side
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] pc_in;
  logic [DW-1:0] aluresult_in;
  logic [DW-1:0] memdata_in;
  logic [RW-1:0] swdst_in;
  logic          regwrite_in;
  logic [MW-1:0] memtoreg_in;
  // downstream side
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] pc;
  logic [DW-1:0] aluresult;
  logic [DW-1:0] memdata;
  logic [RW-1:0] swdst;
  logic          regwrite;
  logic [MW-1:0] memtoreg;
  logic [DW-1:0] wb_data;
  logic          wb_we;
  logic [1:0]    count;

  modport master (
    output flush, in_valid, pc_in, aluresult_in, memdata_in, swdst_in, regwrite_in, memtoreg_in,
    output out_ready,
    input  in_ready, out_valid, pc, aluresult, memdata, swdst, regwrite, memtoreg,
    input  wb_data, wb_we, count
  );

  modport slave (
    input  flush, in_valid, pc_in, aluresult_in, memdata_in, swdst_in, regwrite_in, memtoreg_in,
    input  out_ready,
    output in_ready, out_valid, pc, aluresult, memdata, swdst, regwrite, memtoreg,
    output wb_data, wb_we, count
  );
endinterface

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a two-entry skid buffer.
// Holds a head entry (drives the outputs) and a skid entry that absorbs one extra bundle when
// writeback stalls, so in_ready is a pure function of state and never depends on out_ready.
// Also selects the writeback value and qualifies the register-file write enable.
// Ports:
//   clk  - clock, all state updates on the rising edge.
//   rst  - asynchronous active-low reset.
//   bus  - mem_wb_skid_if.slave: flush, in_* handshake/payload, out_* handshake/head fields,
//          wb_data, wb_we and the 0..2 occupancy count.
module mem_wb_skid #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned MW = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_skid_if.slave  bus
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] aluresult;
    logic [DW-1:0] memdata;
    logic [RW-1:0] swdst;
    logic          regwrite;
    logic [MW-1:0] memtoreg;
  } entry_t;

  // Encoding doubles as the count output.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic release_head;

  assign in_entry = '{
    pc:        bus.pc_in,
    aluresult: bus.aluresult_in,
    memdata:   bus.memdata_in,
    swdst:     bus.swdst_in,
    regwrite:  bus.regwrite_in,
    memtoreg:  bus.memtoreg_in
  };

  // Handshake decode straight from state: no in_valid/out_ready to in_ready path.
  assign in_ready     = (state_q != StFull);
  assign out_valid    = (state_q != StEmpty);
  assign accept       = bus.in_valid & in_ready;
  assign release_head = out_valid & bus.out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !release_head) begin
            state_d = StFull;
          end else if (!accept && release_head) begin
            state_d = StEmpty;
          end
        end
        StFull:  if (release_head) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Entry payload next-state: entries only change when loaded, flushed or reset.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (bus.flush) begin
      // Flush kills write intent but leaves the payload visible for debug.
      head_d.regwrite = 1'b0;
      skid_d.regwrite = 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) head_d = in_entry;
        StOne: begin
          if (accept && release_head) begin
            head_d = in_entry;
          end else if (accept) begin
            skid_d = in_entry;
          end
        end
        StFull:  if (release_head) head_d = skid_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Outputs
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.count     = state_q;
    bus.pc        = head_q.pc;
    bus.aluresult = head_q.aluresult;
    bus.memdata   = head_q.memdata;
    bus.swdst     = head_q.swdst;
    bus.memtoreg  = head_q.memtoreg;
    bus.regwrite  = head_q.regwrite & out_valid;
    if (head_q.memtoreg == MW'(0)) begin
      bus.wb_data = head_q.aluresult;
    end else if (head_q.memtoreg == MW'(1)) begin
      bus.wb_data = head_q.memdata;
    end else begin
      bus.wb_data = head_q.pc + DW'(4);
    end
    // r0 is hardwired zero, so never request a write to it.
    bus.wb_we = release_head & head_q.regwrite & (head_q.swdst != '0);
  end

endmodule
